// File: rtl/intrapred_pkg.sv
// Shared types and helpers for the intra-prediction path (predictor, reconstructor, saver).
// Block geometry defaults and the pixel clip live here so every stage agrees on them.
package intrapred_pkg;

    localparam int DEF_MB_SIZE_L = 8;
    localparam int DEF_MB_SIZE_W = 8;
    localparam int DEF_RES_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECON = 2'd1,
        SAVE  = 2'd2,
        DONE  = 2'd3
    } recon_state_t;

    // Saturate a prediction+residual sum (-256..510) into an 8-bit pixel.
    function automatic logic [7:0] clip_u8(input logic signed [9:0] sum);
        if (sum < 10'sd0)
            return 8'd0;
        else if (sum > 10'sd255)
            return 8'd255;
        else
            return sum[7:0];
    endfunction

endpackage

// File: rtl/recon_row.sv
// One row of reconstruction: MB_SIZE_W parallel pred+resid adders, each clipped to 0..255.
// Purely combinational; the parent registers the result.
module recon_row
    import intrapred_pkg::*;
#(
    parameter int MB_SIZE_W = DEF_MB_SIZE_W,
    parameter int RES_WIDTH = DEF_RES_WIDTH
) (
    input  logic [8*MB_SIZE_W-1:0]         pred_row,
    input  logic [RES_WIDTH*MB_SIZE_W-1:0] resid_row,
    output logic [8*MB_SIZE_W-1:0]         pix_row
);

    for (genvar c = 0; c < MB_SIZE_W; c++) begin : g_px
        logic signed [RES_WIDTH-1:0] r;
        logic signed [9:0]           p10;
        logic signed [9:0]           r10;
        logic signed [9:0]           sum;

        assign r   = resid_row[c*RES_WIDTH +: RES_WIDTH];
        assign p10 = signed'({2'b00, pred_row[c*8 +: 8]});
        assign r10 = 10'(r);
        assign sum = p10 + r10;
        assign pix_row[c*8 +: 8] = clip_u8(sum);
    end

endmodule

// File: rtl/mb_reconstructor.sv
// Reconstructs one macroblock (pred + resid, clipped) one row per cycle, then strobes
// the finished block to the frame-buffer saver and reports completion with done.
module mb_reconstructor
    import intrapred_pkg::*;
#(
    parameter int MB_SIZE_L = DEF_MB_SIZE_L,
    parameter int MB_SIZE_W = DEF_MB_SIZE_W,
    parameter int RES_WIDTH = DEF_RES_WIDTH
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [31:0]                                 mbnumber_in,
    input  logic [8*MB_SIZE_L*MB_SIZE_W-1:0]            pred,
    input  logic signed [RES_WIDTH*MB_SIZE_L*MB_SIZE_W-1:0] resid,
    output logic                                        busy,
    output logic                                        enable,
    output logic [31:0]                                 mbnumber,
    output logic [8*MB_SIZE_L*MB_SIZE_W-1:0]            reconst,
    output logic                                        done
);

    localparam int N         = MB_SIZE_L * MB_SIZE_W;
    localparam int ROW_W     = 8 * MB_SIZE_W;
    localparam int RES_ROW_W = RES_WIDTH * MB_SIZE_W;
    localparam int CNT_W     = (MB_SIZE_L > 1) ? $clog2(MB_SIZE_L) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(MB_SIZE_L - 1);

    recon_state_t state, state_nxt;
    logic         accept;
    logic         row_we;
    logic         last_row;

    logic [CNT_W-1:0]       row_cnt;
    logic [8*N-1:0]         pred_p0;
    logic [RES_WIDTH*N-1:0] resid_p0;
    logic [ROW_W-1:0]       pred_row;
    logic [RES_ROW_W-1:0]   resid_row;
    logic [ROW_W-1:0]       pix_row;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        row_we    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RECON;
                end
            end
            RECON: begin
                row_we = 1'b1;
                if (row_cnt == LAST_ROW)
                    state_nxt = SAVE;
            end
            SAVE:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign last_row = row_we && (row_cnt == LAST_ROW);
    assign busy     = (state != IDLE);

    // Stage p0: operands frozen at accept so upstream is free to move on.
    always_ff @(posedge clk) begin
        if (accept) begin
            pred_p0  <= pred;
            resid_p0 <= resid;
        end
    end

    assign pred_row  = pred_p0[row_cnt*ROW_W +: ROW_W];
    assign resid_row = resid_p0[row_cnt*RES_ROW_W +: RES_ROW_W];

    recon_row #(
        .MB_SIZE_W (MB_SIZE_W),
        .RES_WIDTH (RES_WIDTH)
    ) u_recon_row (
        .pred_row  (pred_row),
        .resid_row (resid_row),
        .pix_row   (pix_row)
    );

    // Stage p1: registered rows and saver-facing strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_cnt  <= '0;
            enable   <= 1'b0;
            done     <= 1'b0;
            mbnumber <= '0;
            reconst  <= '0;
        end else begin
            enable <= last_row;
            done   <= (state == SAVE);
            if (accept) begin
                row_cnt  <= '0;
                mbnumber <= mbnumber_in;
            end else if (row_we) begin
                reconst[row_cnt*ROW_W +: ROW_W] <= pix_row;
                row_cnt <= row_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mb_reconstructor.sv
// Self-checking bench for mb_reconstructor: scoreboard of expected blocks plus timing checks.
module tb_mb_reconstructor;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [31:0]  mbnumber_in;
    logic [511:0] pred;
    logic [575:0] resid;
    logic         busy;
    logic         enable;
    logic [31:0]  mbnumber;
    logic [511:0] reconst;
    logic         done;

    typedef struct {
        logic [31:0]  mb;
        logic [511:0] pix;
    } exp_t;

    exp_t         sb[$];
    int           checks     = 0;
    int           failures   = 0;
    int           enable_cnt = 0;
    logic [511:0] last_pix;

    mb_reconstructor dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mbnumber_in (mbnumber_in),
        .pred        (pred),
        .resid       (resid),
        .busy        (busy),
        .enable      (enable),
        .mbnumber    (mbnumber),
        .reconst     (reconst),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (enable === 1'b1) enable_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [511:0] model(input logic [511:0] p, input logic [575:0] r);
        logic [511:0] o;
        int s;
        o = '0;
        for (int i = 0; i < 64; i++) begin
            s = int'(p[i*8 +: 8]) + int'($signed(r[i*9 +: 9]));
            if (s < 0) s = 0;
            else if (s > 255) s = 255;
            o[i*8 +: 8] = 8'(s);
        end
        return o;
    endfunction

    function automatic logic [511:0] with_rows(input logic [511:0] old_b, input logic [511:0] new_b,
                                               input int nrows);
        logic [511:0] o;
        o = old_b;
        for (int i = 0; i < nrows * 64; i++) o[i] = new_b[i];
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_block(input logic [31:0] mb, input logic [511:0] p, input logic [575:0] r);
        exp_t e;
        mbnumber_in = mb;
        pred        = p;
        resid       = r;
        e.mb        = mb;
        e.pix       = model(p, r);
        sb.push_back(e);
    endtask

    task automatic rand_ops(output logic [511:0] p, output logic [575:0] r);
        for (int i = 0; i < 64; i++) begin
            p[i*8 +: 8] = 8'($urandom);
            r[i*9 +: 9] = 9'($urandom);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        mbnumber_in = '0;
        pred = '0;
        resid = '0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b want=0", enable); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (mbnumber !== 32'h0) begin failures++; $display("FAIL reset_mbnumber got=%h want=0", mbnumber); end
        checks++; if (reconst !== 512'h0) begin failures++; $display("FAIL reset_reconst got=%h want=0", reconst); end
        reset = 1'b0;
        tick();
        last_pix = '0;
    endtask

    task automatic test_ramp();
        logic [511:0] p;
        exp_t e;
        int early;
        for (int i = 0; i < 64; i++) p[i*8 +: 8] = 8'(i);
        load_block(32'h0010_0020, p, '0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ramp_busy_e0 got=%b want=1", busy); end
        early = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (enable !== 1'b0) early++;
        end
        checks++; if (early != 0) begin failures++; $display("FAIL ramp_enable_early got=%0d want=0", early); end
        tick();
        if (sb.size() != 0) e = sb.pop_front(); else begin e.mb = 'x; e.pix = 'x; end
        checks++; if (enable !== 1'b1) begin failures++; $display("FAIL ramp_enable_e8 got=%b want=1", enable); end
        checks++; if (reconst !== e.pix) begin failures++; $display("FAIL ramp_reconst got=%h want=%h", reconst, e.pix); end
        checks++; if (reconst[63*8 +: 8] !== 8'd63) begin failures++; $display("FAIL ramp_px63 got=%0d want=63", reconst[63*8 +: 8]); end
        checks++; if (mbnumber !== 32'h0010_0020) begin failures++; $display("FAIL ramp_mbnumber got=%h want=00100020", mbnumber); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL ramp_done_e8 got=%b want=0", done); end
        tick();
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL ramp_enable_e9 got=%b want=0", enable); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ramp_done_e9 got=%b want=1", done); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL ramp_done_e10 got=%b want=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ramp_busy_e10 got=%b want=0", busy); end
        last_pix = e.pix;
    endtask

    task automatic test_clip();
        logic [511:0] p;
        logic [575:0] r;
        exp_t e;
        bit got;
        int pv, rv;
        for (int i = 0; i < 64; i++) begin
            case (i % 5)
                0: begin pv = 250; rv = 20;   end
                1: begin pv = 3;   rv = -10;  end
                2: begin pv = 0;   rv = -256; end
                3: begin pv = 255; rv = 255;  end
                default: begin pv = 100; rv = -1; end
            endcase
            p[i*8 +: 8] = 8'(pv);
            r[i*9 +: 9] = 9'(rv);
        end
        load_block(32'h0020_0040, p, r);
        start = 1'b1;
        tick();
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            tick();
            if (enable === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin failures++; $display("FAIL clip_enable_timeout got=0 want=1"); end
        if (sb.size() != 0) e = sb.pop_front(); else begin e.mb = 'x; e.pix = 'x; end
        checks++; if (reconst !== e.pix) begin failures++; $display("FAIL clip_reconst got=%h want=%h", reconst, e.pix); end
        checks++; if (reconst[0 +: 8] !== 8'd255) begin failures++; $display("FAIL clip_hi got=%0d want=255", reconst[0 +: 8]); end
        checks++; if (reconst[8 +: 8] !== 8'd0) begin failures++; $display("FAIL clip_lo got=%0d want=0", reconst[8 +: 8]); end
        checks++; if (reconst[16 +: 8] !== 8'd0) begin failures++; $display("FAIL clip_min got=%0d want=0", reconst[16 +: 8]); end
        checks++; if (reconst[24 +: 8] !== 8'd255) begin failures++; $display("FAIL clip_max got=%0d want=255", reconst[24 +: 8]); end
        checks++; if (reconst[32 +: 8] !== 8'd99) begin failures++; $display("FAIL clip_mid got=%0d want=99", reconst[32 +: 8]); end
        checks++; if (mbnumber !== 32'h0020_0040) begin failures++; $display("FAIL clip_mbnumber got=%h want=00200040", mbnumber); end
        tick();
        tick();
        last_pix = e.pix;
    endtask

    task automatic test_rows();
        logic [511:0] p;
        logic [511:0] newb;
        logic [511:0] want;
        exp_t e;
        for (int i = 0; i < 64; i++) p[i*8 +: 8] = 8'(10 * (i / 8) + 5);
        load_block(32'h0001_0001, p, '0);
        newb = sb[sb.size()-1].pix;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 8; r++) begin
            tick();
            want = with_rows(last_pix, newb, r + 1);
            checks++;
            if (reconst !== want) begin
                failures++;
                $display("FAIL rows_after_e%0d got=%h want=%h", r + 1, reconst, want);
            end
        end
        if (sb.size() != 0) e = sb.pop_front(); else begin e.mb = 'x; e.pix = 'x; end
        checks++; if (enable !== 1'b1 || reconst !== e.pix) begin failures++; $display("FAIL rows_final en=%b got=%h want=%h", enable, reconst, e.pix); end
        tick();
        tick();
        last_pix = e.pix;
    endtask

    task automatic test_start_held();
        logic [511:0] p;
        logic [575:0] r;
        exp_t e;
        int seen;
        seen = 0;
        rand_ops(p, r);
        load_block(32'h0000_0100, p, r);
        start = 1'b1;
        tick();
        rand_ops(p, r);
        load_block(32'h0000_0200, p, r);
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (c == 10) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL held_idle_gap got=%b want=0", busy); end
            end
            if (c == 11) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL held_accept_e11 got=%b want=1", busy); end
                rand_ops(p, r);
                load_block(32'h0000_0300, p, r);
            end
            if (c == 22) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL held_accept_e22 got=%b want=1", busy); end
                rand_ops(p, r);
                mbnumber_in = 32'h0000_0400;
                pred = p;
                resid = r;
                start = 1'b0;
            end
            if (enable === 1'b1) begin
                seen++;
                checks++;
                if (!(c == 8 || c == 19 || c == 30)) begin
                    failures++;
                    $display("FAIL held_enable_cycle got=%0d want=8/19/30", c);
                end
                if (sb.size() != 0) e = sb.pop_front(); else begin e.mb = 'x; e.pix = 'x; end
                checks++; if (reconst !== e.pix) begin failures++; $display("FAIL held_reconst got=%h want=%h", reconst, e.pix); end
                checks++; if (mbnumber !== e.mb) begin failures++; $display("FAIL held_mbnumber got=%h want=%h", mbnumber, e.mb); end
                last_pix = e.pix;
            end
        end
        start = 1'b0;
        checks++; if (seen != 3) begin failures++; $display("FAIL held_enable_count got=%0d want=3", seen); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [511:0] p;
        logic [575:0] r;
        exp_t e;
        int en0;
        bit got;
        rand_ops(p, r);
        load_block(32'h0300_0300, p, r);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        if (sb.size() != 0) void'(sb.pop_back());
        checks++;
        if (busy !== 1'b0 || enable !== 1'b0 || done !== 1'b0 || mbnumber !== 32'h0 || reconst !== 512'h0) begin
            failures++;
            $display("FAIL abort_outputs got=b%b e%b d%b mb=%h want=all zero", busy, enable, done, mbnumber);
        end
        en0 = enable_cnt;
        tick();
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        checks++; if (enable_cnt != en0) begin failures++; $display("FAIL abort_no_enable got=%0d want=%0d", enable_cnt, en0); end
        rand_ops(p, r);
        load_block(32'h0004_0008, p, r);
        start = 1'b1;
        tick();
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            tick();
            if (enable === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin failures++; $display("FAIL abort_recover_timeout got=0 want=1"); end
        if (sb.size() != 0) e = sb.pop_front(); else begin e.mb = 'x; e.pix = 'x; end
        checks++; if (reconst !== e.pix) begin failures++; $display("FAIL abort_recover_reconst got=%h want=%h", reconst, e.pix); end
        checks++; if (mbnumber !== e.mb) begin failures++; $display("FAIL abort_recover_mb got=%h want=%h", mbnumber, e.mb); end
        tick();
        tick();
        last_pix = e.pix;
    endtask

    task automatic test_back_to_back();
        logic [511:0] p;
        logic [575:0] r;
        logic [511:0] blk1;
        logic [511:0] blk2;
        exp_t e;
        bit got;
        for (int b = 0; b < 2; b++) begin
            rand_ops(p, r);
            load_block(b == 0 ? 32'h0000_0000 : 32'h0000_0008, p, r);
            if (b == 1) begin
                blk2 = sb[sb.size()-1].pix;
                checks++; if (mbnumber !== 32'h0) begin failures++; $display("FAIL b2b_mb_before got=%h want=0", mbnumber); end
            end
            start = 1'b1;
            tick();
            start = 1'b0;
            if (b == 1) begin
                checks++; if (mbnumber !== 32'h8) begin failures++; $display("FAIL b2b_mb_accept got=%h want=8", mbnumber); end
                checks++; if (reconst !== blk1) begin failures++; $display("FAIL b2b_hold_e0 got=%h want=%h", reconst, blk1); end
                tick();
                checks++;
                if (reconst !== with_rows(blk1, blk2, 1)) begin
                    failures++;
                    $display("FAIL b2b_row0_e1 got=%h want=%h", reconst, with_rows(blk1, blk2, 1));
                end
            end
            got = 1'b0;
            for (int k = 0; k < 12 && !got; k++) begin
                tick();
                if (enable === 1'b1) got = 1'b1;
            end
            checks++; if (!got) begin failures++; $display("FAIL b2b_enable_timeout blk=%0d got=0 want=1", b); end
            if (sb.size() != 0) e = sb.pop_front(); else begin e.mb = 'x; e.pix = 'x; end
            checks++; if (reconst !== e.pix) begin failures++; $display("FAIL b2b_reconst blk=%0d got=%h want=%h", b, reconst, e.pix); end
            checks++; if (mbnumber !== e.mb) begin failures++; $display("FAIL b2b_mbnumber blk=%0d got=%h want=%h", b, mbnumber, e.mb); end
            if (b == 0) blk1 = e.pix;
            tick();
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_ramp();
        test_clip();
        test_rows();
        test_start_held();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
